// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Front-end fetch stage. Keeps the fetch PC, issues in-order 32-bit word reads
// to instruction memory under a credit limit, buffers returned words together
// with their PCs in a small FIFO and presents the FIFO head to the decoder.
// A redirect replaces the fetch PC, flushes the FIFO and arranges for every
// word still in flight to be dropped when it returns.
//
// Parameters
//   RESET_PC    fetch address after reset
//   FIFO_DEPTH  instruction buffer entries; also the maximum number of
//               requests in flight plus buffered words
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   mem_req_valid/ready/addr         word read request (addr[1:0] always 0)
//   mem_resp_valid/data              in-order read data, never back-pressured
//   instruction_data/valid/pc        FIFO head towards the decoder
//   instruction_ready                decoder consumes the head this cycle
//   redirect_valid/pc                new fetch target (branch/jump/trap)
//   fetch_fault/fetch_fault_pc       misaligned redirect target report
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a target with
//   redirect_pc[1:0] != 0 raises a sticky fetch_fault and stops fetching until
//   the next aligned redirect or reset. When undefined the low two target bits
//   are ignored and the fault outputs are tied to zero.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] instruction_data,
    output logic        instruction_data_valid,
    output logic [31:0] instruction_pc,
    input  logic        instruction_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_fault_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W:0]   DEPTH_CNT = FIFO_DEPTH[CNT_W:0];
    localparam logic [CNT_W-1:0] FULL_CNT  = FIFO_DEPTH[CNT_W-1:0];
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // Word-align a byte address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Control state
    logic [31:0]      fetch_pc;
    logic [31:0]      pc_tag;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             fault;
    logic [31:0]      fault_pc;

    // Buffer storage (data only, never reset)
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [31:0] fifo_pc   [FIFO_DEPTH];

    logic [CNT_W:0]   in_use;
    logic             credit_ok;
    logic             accept;
    logic             push;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] resp_cnt;
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] pop_cnt;
    logic [31:0]      redirect_target;
    logic             target_misaligned;

    // ---- request stage: credit check and fetch address ----
    // Every accepted request owns a FIFO slot until its word is consumed or
    // dropped, so the buffer can never overflow.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = (in_use < DEPTH_CNT);

    assign mem_req_valid = !rst && !redirect_valid && !fault && credit_ok;
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;

    assign redirect_target = word_align(redirect_pc);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_pc[1:0];
    assign target_misaligned  = 1'b0;
`endif

    // ---- response stage: drop stale words, buffer the rest ----
    // A response in a redirect cycle belongs to the old stream and is dropped
    // implicitly: it is excluded from the new discard count and not pushed.
    assign drop = mem_resp_valid && (discard != '0);
    assign push = mem_resp_valid && !redirect_valid && (discard == '0);

    // ---- output stage: FIFO head to the decoder ----
    assign instruction_data_valid = (fifo_count != '0);
    assign instruction_data       = fifo_data[rd_ptr];
    assign instruction_pc         = fifo_pc[rd_ptr];
    assign pop = instruction_data_valid && instruction_ready && !redirect_valid;

    assign acc_cnt  = CNT_W'(accept);
    assign resp_cnt = CNT_W'(mem_resp_valid);
    assign push_cnt = CNT_W'(push);
    assign pop_cnt  = CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            pc_tag      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight, minus a response arriving right
            // now, returns later and must be thrown away.
            fetch_pc    <= redirect_target;
            pc_tag      <= redirect_target;
            outstanding <= outstanding - resp_cnt;
            discard     <= outstanding - resp_cnt;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + acc_cnt - resp_cnt;
            if (drop) begin
                discard <= discard - CNT_W'(1);
            end
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
                pc_tag <= pc_tag + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            fifo_count <= fifo_count + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_resp_data;
            fifo_pc[wr_ptr]   <= pc_tag;
        end
    end

    // ---- fault reporting ----
`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky until the next aligned redirect; in-flight words are still
    // discarded through the normal redirect path above.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (redirect_valid) begin
            if (target_misaligned) begin
                fault    <= 1'b1;
                fault_pc <= redirect_pc;
            end else begin
                fault <= 1'b0;
            end
        end
    end
`else
    assign fault    = target_misaligned;
    assign fault_pc = '0;
`endif

    assign fetch_fault    = fault;
    assign fetch_fault_pc = fault_pc;

    // Structural invariants of the credit scheme.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_count == FULL_CNT)));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        in_use <= DEPTH_CNT);
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        discard <= outstanding);

endmodule
